// File: rtl/nand_checker.sv
// Response checker for a two-input gate: compares z against TRUTH[{x,y}].
// Optional first-error capture ports when NAND_CHECKER_FIRST_ERR_EN is defined.
module nand_checker #(
  parameter logic [3:0] TRUTH = 4'b0111,
  parameter int         CW    = 8,
  parameter int         NVEC  = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic          x,
  input  logic          y,
  input  logic          z,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] vec_count,
  output logic [CW-1:0] err_count,
  output logic [3:0]    coverage
`ifdef NAND_CHECKER_FIRST_ERR_EN
  ,
  output logic          first_err_valid,
  output logic [2:0]    first_err_vec,
  output logic [CW-1:0] first_err_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] C_MAX  = '1;
  localparam logic [CW-1:0] C_NVEC = CW'(NVEC);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_vec;
  logic [CW-1:0] r_err;
  logic [3:0]    r_cov;
  logic          r_pass;
  logic [CW-1:0] w_vec_nxt;
  logic [CW-1:0] w_err_nxt;
  logic [3:0]    w_cov_nxt;
  logic          w_pass_nxt;
  logic [1:0]    w_idx;
  logic          w_mis;
  logic          w_accept;
  logic          w_clear;

  assign w_idx    = {x, y};
  // X or Z on z must count as a mismatch, hence the case inequality
  assign w_mis    = (z !== TRUTH[w_idx]);
  assign w_accept = in_valid && (r_state == S_RUN);
  assign w_clear  = start && (r_state != S_IDLE || 1'b1);

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_err_nxt   = r_err;
    w_cov_nxt   = r_cov;
    w_pass_nxt  = r_pass;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_vec_nxt   = '0;
          w_err_nxt   = '0;
          w_cov_nxt   = '0;
          w_pass_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        if (start) begin
          w_vec_nxt = '0;
          w_err_nxt = '0;
          w_cov_nxt = '0;
        end else if (in_valid) begin
          if (r_vec != C_MAX)
            w_vec_nxt = r_vec + 1'b1;
          if (w_mis && r_err != C_MAX)
            w_err_nxt = r_err + 1'b1;
          w_cov_nxt = r_cov | (4'b0001 << w_idx);
          if (w_vec_nxt >= C_NVEC && w_cov_nxt == 4'hF) begin
            w_state_nxt = S_DONE;
            w_pass_nxt  = (w_err_nxt == '0);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_err   <= '0;
      r_cov   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_err   <= w_err_nxt;
      r_cov   <= w_cov_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  assign in_ready  = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign vec_count = r_vec;
  assign err_count = r_err;
  assign coverage  = r_cov;

`ifdef NAND_CHECKER_FIRST_ERR_EN
  logic          r_fe_valid;
  logic [2:0]    r_fe_vec;
  logic [CW-1:0] r_fe_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fe_valid <= 1'b0;
      r_fe_vec   <= '0;
      r_fe_idx   <= '0;
    end else if (w_clear) begin
      r_fe_valid <= 1'b0;
      r_fe_vec   <= '0;
      r_fe_idx   <= '0;
    end else if (w_accept && w_mis && !r_fe_valid) begin
      r_fe_valid <= 1'b1;
      r_fe_vec   <= {x, y, z};
      r_fe_idx   <= r_vec;
    end
  end

  assign first_err_valid = r_fe_valid;
  assign first_err_vec   = r_fe_vec;
  assign first_err_idx   = r_fe_idx;
`endif

endmodule

// File: tb/tb_nand_checker.sv
// Directed bench for nand_checker: table of steps plus saturation sequences.
// Optional first-error ports checked when NAND_CHECKER_FIRST_ERR_EN is defined.
module tb_nand_checker;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic start_c = 1'b0;
  logic in_valid = 1'b0;
  logic x = 1'b0;
  logic y = 1'b0;
  logic z = 1'b0;

  logic       rdy_a, busy_a, done_a, pass_a;
  logic [7:0] vec_a, err_a;
  logic [3:0] cov_a;
  logic       rdy_b, busy_b, done_b, pass_b;
  logic [2:0] vec_b, err_b;
  logic [3:0] cov_b;
  logic       rdy_c, busy_c, done_c, pass_c;
  logic [2:0] vec_c, err_c;
  logic [3:0] cov_c;
`ifdef NAND_CHECKER_FIRST_ERR_EN
  logic       fev_a, fev_b, fev_c;
  logic [2:0] fe_vec_a, fe_vec_b, fe_vec_c;
  logic [7:0] fe_idx_a;
  logic [2:0] fe_idx_b, fe_idx_c;
`endif

  always #5 clock = ~clock;

  nand_checker u_a (
    .clock(clock), .reset(reset), .start(start_a),
    .in_valid(in_valid), .x(x), .y(y), .z(z),
    .in_ready(rdy_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .vec_count(vec_a), .err_count(err_a),
    .coverage(cov_a)
`ifdef NAND_CHECKER_FIRST_ERR_EN
    , .first_err_valid(fev_a), .first_err_vec(fe_vec_a),
    .first_err_idx(fe_idx_a)
`endif
  );

  nand_checker #(.CW(3), .NVEC(4)) u_b (
    .clock(clock), .reset(reset), .start(start_b),
    .in_valid(in_valid), .x(x), .y(y), .z(z),
    .in_ready(rdy_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .vec_count(vec_b), .err_count(err_b),
    .coverage(cov_b)
`ifdef NAND_CHECKER_FIRST_ERR_EN
    , .first_err_valid(fev_b), .first_err_vec(fe_vec_b),
    .first_err_idx(fe_idx_b)
`endif
  );

  nand_checker #(.CW(3), .NVEC(7)) u_c (
    .clock(clock), .reset(reset), .start(start_c),
    .in_valid(in_valid), .x(x), .y(y), .z(z),
    .in_ready(rdy_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .vec_count(vec_c), .err_count(err_c),
    .coverage(cov_c)
`ifdef NAND_CHECKER_FIRST_ERR_EN
    , .first_err_valid(fev_c), .first_err_vec(fe_vec_c),
    .first_err_idx(fe_idx_c)
`endif
  );

  typedef struct {
    logic       rst, st, v, x, y, z;
    logic       busy, done, pass;
    logic [7:0] vec, err;
    logic [3:0] cov;
  } step_t;

  step_t tbl[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic void add(
    input logic rst, st, v, xi, yi, zi,
    input logic eb, ed, ep,
    input int ev, ee, input logic [3:0] ec);
    step_t s;
    s.rst = rst; s.st = st; s.v = v;
    s.x = xi; s.y = yi; s.z = zi;
    s.busy = eb; s.done = ed; s.pass = ep;
    s.vec = 8'(ev); s.err = 8'(ee); s.cov = ec;
    tbl.push_back(s);
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h",
               nm, idx, got, exp);
    end
  endtask

  task automatic drive(input logic st_b, st_c, v,
                       input logic xi, yi, zi);
    start_b = st_b; start_c = st_c;
    in_valid = v; x = xi; y = yi; z = zi;
    @(posedge clock);
    #1;
    n_vec++;
    start_b = 0; start_c = 0; in_valid = 0;
  endtask

  initial begin
    // rst st v x y z | busy done pass vec err cov
    add(1,0,0,0,0,0, 0,0,0, 0,0,4'h0);
    add(0,0,1,0,0,1, 0,0,0, 0,0,4'h0);
    add(0,1,0,0,0,0, 1,0,0, 0,0,4'h0);
    add(0,0,1,0,0,1, 1,0,0, 1,0,4'h1);
    add(0,0,1,1,0,1, 1,0,0, 2,0,4'h5);
    add(0,0,1,0,1,1, 1,0,0, 3,0,4'h7);
    add(0,0,1,1,1,0, 1,0,0, 4,0,4'hF);
    add(0,0,1,0,0,1, 0,1,1, 5,0,4'hF);
    add(0,0,1,0,0,0, 0,1,1, 5,0,4'hF);
    add(0,1,1,1,1,0, 1,0,0, 0,0,4'h0);
    add(0,0,1,0,0,1, 1,0,0, 1,0,4'h1);
    add(0,0,1,1,0,1, 1,0,0, 2,0,4'h5);
    add(0,0,1,0,1,1, 1,0,0, 3,0,4'h7);
    add(0,0,1,1,1,1, 1,0,0, 4,1,4'hF);
    add(0,0,1,0,0,1, 0,1,0, 5,1,4'hF);
    add(0,1,0,0,0,0, 1,0,0, 0,0,4'h0);
    for (int i = 1; i <= 6; i++)
      add(0,0,1,0,0,1, 1,0,0, i,0,4'h1);
    add(0,0,1,1,0,1, 1,0,0, 7,0,4'h5);
    add(0,0,1,0,1,1, 1,0,0, 8,0,4'h7);
    add(0,0,1,1,1,0, 0,1,1, 9,0,4'hF);
    add(1,0,0,0,0,0, 0,0,0, 0,0,4'h0);
    add(0,0,1,0,0,1, 0,0,0, 0,0,4'h0);
    add(0,1,0,0,0,0, 1,0,0, 0,0,4'h0);
    add(0,0,1,0,0,1, 1,0,0, 1,0,4'h1);
    add(0,0,1,1,0,1, 1,0,0, 2,0,4'h5);
    add(0,0,1,0,1,0, 1,0,0, 3,1,4'h7);
    add(1,1,1,1,1,0, 0,0,0, 0,0,4'h0);
    add(0,1,0,0,0,0, 1,0,0, 0,0,4'h0);
    add(0,0,1,0,0,1, 1,0,0, 1,0,4'h1);
    add(0,0,1,1,0,1, 1,0,0, 2,0,4'h5);
    add(0,1,1,0,0,1, 1,0,0, 0,0,4'h0);
    add(0,0,1,1,1,0, 1,0,0, 1,0,4'h8);

    @(posedge clock);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; start_a = tbl[i].st;
      in_valid = tbl[i].v;
      x = tbl[i].x; y = tbl[i].y; z = tbl[i].z;
      @(posedge clock);
      #1;
      n_vec++;
      chk("busy", i, 32'(busy_a), 32'(tbl[i].busy));
      chk("in_ready", i, 32'(rdy_a), 32'(tbl[i].busy));
      chk("done", i, 32'(done_a), 32'(tbl[i].done));
      chk("pass", i, 32'(pass_a), 32'(tbl[i].pass));
      chk("vec_count", i, 32'(vec_a), 32'(tbl[i].vec));
      chk("err_count", i, 32'(err_a), 32'(tbl[i].err));
      chk("coverage", i, 32'(cov_a), 32'(tbl[i].cov));
`ifdef NAND_CHECKER_FIRST_ERR_EN
      if (i == 14) begin
        chk("fe_valid", i, 32'(fev_a), 32'd1);
        chk("fe_vec", i, 32'(fe_vec_a), 32'b111);
        chk("fe_idx", i, 32'(fe_idx_a), 32'd3);
      end
      if (i == 15)
        chk("fe_clear", i, 32'(fev_a), 32'd0);
`endif
    end
    reset = 0; start_a = 0; in_valid = 0;

    // CW=3 NVEC=4: four mismatches covering all inputs
    drive(1,0,0,0,0,0);
    drive(0,0,1,0,0,0);
    drive(0,0,1,0,1,0);
    drive(0,0,1,1,0,0);
    chk("b_done_early", 100, 32'(done_b), 32'd0);
    drive(0,0,1,1,1,1);
    chk("b_done", 101, 32'(done_b), 32'd1);
    chk("b_err", 101, 32'(err_b), 32'd4);
    chk("b_vec", 101, 32'(vec_b), 32'd4);
    chk("b_pass", 101, 32'(pass_b), 32'd0);
`ifdef NAND_CHECKER_FIRST_ERR_EN
    chk("b_fe_vec", 101, 32'(fe_vec_b), 32'b000);
    chk("b_fe_idx", 101, 32'(fe_idx_b), 32'd0);
`endif
    for (int k = 0; k < 5; k++)
      drive(0,0,1,1,1,1);
    chk("b_err_hold", 102, 32'(err_b), 32'd4);
    chk("b_vec_hold", 102, 32'(vec_b), 32'd4);

    // CW=3 NVEC=7: X on z, then 8 more mismatches on {0,0}
    drive(0,1,0,0,0,0);
    drive(0,0,1,0,0,1'bx);
    chk("c_xz_err", 103, 32'(err_c), 32'd1);
    for (int k = 0; k < 8; k++)
      drive(0,0,1,0,0,0);
    chk("c_err_sat", 104, 32'(err_c), 32'd7);
    chk("c_vec_sat", 104, 32'(vec_c), 32'd7);
    chk("c_cov", 104, 32'(cov_c), 32'h1);
    chk("c_busy", 104, 32'(busy_c), 32'd1);
    drive(0,0,1,0,1,1);
    drive(0,0,1,1,0,1);
    drive(0,0,1,1,1,0);
    chk("c_done", 105, 32'(done_c), 32'd1);
    chk("c_pass", 105, 32'(pass_c), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nand_checker.md
Name: nand_checker

Overview:
- Sequential response checker: the receiving/verifying end of the two-input gate stimulus flow.
- Accepts {x, y, z} samples from a stimulus source driving a gate under test and compares z against a parameterised truth table (NAND by default).
- Counts vectors and mismatches, tracks input-combination coverage, and declares pass/fail.
- Synthesisable, so it sits beside the gate modules and replaces manual waveform inspection.

Parameters:
- TRUTH, 4'b0111, expected output indexed by {x,y}; TRUTH[{x,y}]. Default is NAND.
- CW, 8, width of the vector and error counters.
- NVEC, 5, minimum accepted vectors before the run may complete; must satisfy 1 <= NVEC <= 2^CW-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or restarts a run.
- in_valid  in  1  {x,y,z} sample valid this cycle.
- x  in  1  gate input A as driven.
- y  in  1  gate input B as driven.
- z  in  1  gate output as observed.
- in_ready  out  1  checker accepts a sample this cycle.
- busy  out  1  run in progress.
- done  out  1  run complete; held until start or reset.
- pass  out  1  valid when done=1: no errors and full coverage.
- vec_count  out  CW  accepted vectors, saturating.
- err_count  out  CW  mismatching vectors, saturating.
- coverage  out  4  bit k set once {x,y}==k has been accepted.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Ports are named clock and reset.
- Reset values:
  - State IDLE.
  - in_ready, busy, done and pass are 0.
  - vec_count, err_count and coverage are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0; samples are ignored.
  - start causes the following next-cycle updates: clear vec_count, err_count and coverage; go to RUN.
- RUN:
  - busy=1 and in_ready=1 (combinational from state).
  - A sample is accepted when in_valid && in_ready.
  - On accept, with updates registered and visible the next cycle:
    - vec_count increments, saturating at 2^CW-1.
    - coverage[{x,y}] is set.
    - If z !== TRUTH[{x,y}], err_count increments, saturating. An X or Z on z counts as a mismatch.
  - Completion: after an accept, the next state is DONE if the updated vec_count >= NVEC and the updated coverage == 4'hF. Otherwise the FSM stays in RUN.
  - Coverage is never satisfied with only NVEC vectors if one of the four combinations is missing; the run continues indefinitely until it is covered.
- DONE:
  - busy=0, in_ready=0, done=1.
  - pass = (err_count==0) && (coverage==4'hF), registered on entry to DONE.
  - Counters hold their values.
  - start returns the FSM to RUN with counters cleared, and clears done and pass.
- start while in RUN: restart. Counters and coverage clear, and any sample presented in the same cycle is discarded. start has priority over accept.
- reset mid-run: returns to IDLE with all outputs 0 on the next edge, regardless of start or in_valid. reset has priority over everything.
- in_valid outside RUN: ignored, with no counter change.
- Timing: completion latency is one cycle; done rises on the edge after the accept that satisfies the completion condition.

Optional Feature:
- Macro: NAND_CHECKER_FIRST_ERR_EN.
- When defined, three extra outputs are present:
  - first_err_valid (1)
  - first_err_vec (3, {x,y,z})
  - first_err_idx (CW, the vec_count value before the failing accept)
- Capture rule: on the first mismatch of a run, the values are captured and held. They are cleared by start or reset; later mismatches do not overwrite them.
- When not defined, these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Nominal NAND sequence. Stimulus: start, then {x,y,z} = 001, 101, 011, 110, 001 with in_valid=1 for one cycle each. Response:
  - done=1 the cycle after the 5th accept.
  - pass=1, vec_count=5, err_count=0, coverage=4'hF.
- Injected fault. Stimulus: same sequence but 111 at the 4th vector. Response:
  - done=1, pass=0, err_count=1.
  - With NAND_CHECKER_FIRST_ERR_EN: first_err_valid=1, first_err_vec=3'b111, first_err_idx=3.
- Incomplete coverage. Stimulus: 6 accepts of 001, then 101, 011, 110. Response:
  - done stays 0 through the first 8 accepts.
  - done=1 after the 9th accept; vec_count=9, pass=1.
- Saturation (CW=3, NVEC=4). Stimulus: 9 accepts, all mismatching, covering all combinations early. Response:
  - done rises after the 4th accept with err_count=4.
  - With a fresh setting of NVEC=7 and 9 mismatches before coverage completes, err_count saturates at 7.
- Reset and restart:
  - reset asserted after 3 accepts: next cycle, state IDLE, vec_count=0, in_ready=0.
  - Later, start asserted in RUN while in_valid=1: sample discarded, vec_count=0 on the next cycle.
- Ignored samples: in_valid pulses while in IDLE and DONE leave vec_count, err_count and coverage unchanged.
